// File: rtl/leb128_reader_if.sv
// Memory command/response bus between the LEB128 reader (master) and a word-wide read memory (slave).
interface leb128_reader_if;
  logic        mem_cmd_start;
  logic        mem_cmd_write;
  logic        mem_cmd_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rdata_ready;
  logic [31:0] mem_wdata;

  modport master (
    output mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata,
    input  mem_cmd_ready, mem_rdata, mem_rdata_ready
  );

  modport slave (
    input  mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata,
    output mem_cmd_ready, mem_rdata, mem_rdata_ready
  );
endinterface

// File: rtl/leb128_reader.sv
// Decodes one LEB128 value from byte-addressed memory through a one-word read cache.
// Define LEB128_SIGNED_EN to add the signed_mode port and sign extension of the result.
module leb128_reader #(
  parameter int MAX_BYTES = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] start_addr,
`ifdef LEB128_SIGNED_EN
  input  logic        signed_mode,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] value,
  output logic [31:0] next_addr,
  output logic        error,
  leb128_reader_if.master mem
);
  localparam int CW = $clog2(MAX_BYTES + 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DECODE, DONE} state_t;

  state_t         state_q, state_d;
  logic [31:0]    cur_addr_q, cur_addr_d;
  logic [31:0]    acc_q, acc_d;
  logic [CW-1:0]  count_q, count_d;
  logic           cache_valid_q, cache_valid_d;
  logic [29:0]    cache_tag_q, cache_tag_d;
  logic [31:0]    cache_word_q, cache_word_d;
  logic [31:0]    value_q, value_d;
  logic [31:0]    next_addr_q, next_addr_d;
  logic           error_q, error_d;
`ifdef LEB128_SIGNED_EN
  logic           signed_q, signed_d;
  logic [31:0]    shamt_end;
`endif

  logic           cache_hit;
  logic [7:0]     cur_byte;
  logic [31:0]    shamt;
  logic [31:0]    acc_new;
  logic [31:0]    sext_mask;
  logic           last_byte;
  logic           cmd_start;

  assign cache_hit = cache_valid_q && (cache_tag_q == cur_addr_q[31:2]);
  assign shamt     = 32'(count_q) * 32'd7;
  assign acc_new   = acc_q | ({25'd0, cur_byte[6:0]} << shamt);
  assign last_byte = (count_q == CW'(MAX_BYTES - 1));

  // Byte offset 0 sits in the most significant lane of the word.
  always_comb begin
    cur_byte = cache_word_q[31:24];
    case (cur_addr_q[1:0])
      2'd0: cur_byte = cache_word_q[31:24];
      2'd1: cur_byte = cache_word_q[23:16];
      2'd2: cur_byte = cache_word_q[15:8];
      2'd3: cur_byte = cache_word_q[7:0];
      default: cur_byte = cache_word_q[31:24];
    endcase
  end

  always_comb begin
    sext_mask = '0;
`ifdef LEB128_SIGNED_EN
    // Sign bit is bit 6 of the last byte; fill everything above the decoded width.
    shamt_end = shamt + 32'd7;
    if (signed_q && cur_byte[6] && (shamt_end < 32'd32))
      sext_mask = 32'hFFFF_FFFF << shamt_end[4:0];
`endif
  end

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    acc_d         = acc_q;
    count_d       = count_q;
    cache_valid_d = cache_valid_q;
    cache_tag_d   = cache_tag_q;
    cache_word_d  = cache_word_q;
    value_d       = value_q;
    next_addr_d   = next_addr_q;
    error_d       = error_q;
`ifdef LEB128_SIGNED_EN
    signed_d      = signed_q;
`endif
    cmd_start     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cur_addr_d    = start_addr;
          acc_d         = '0;
          count_d       = '0;
          cache_valid_d = 1'b0;
`ifdef LEB128_SIGNED_EN
          signed_d      = signed_mode;
`endif
          state_d       = FETCH;
        end
      end
      FETCH: begin
        if (cache_hit) begin
          state_d = DECODE;
        end else if (mem.mem_cmd_ready) begin
          cmd_start = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // rdata_ready alone may be left over from the previous read; ready must accompany it.
        if (mem.mem_cmd_ready && mem.mem_rdata_ready) begin
          cache_word_d  = mem.mem_rdata;
          cache_tag_d   = cur_addr_q[31:2];
          cache_valid_d = 1'b1;
          state_d       = DECODE;
        end
      end
      DECODE: begin
        acc_d      = acc_new;
        cur_addr_d = cur_addr_q + 32'd1;
        count_d    = count_q + CW'(1);
        if (!cur_byte[7] || last_byte) begin
          value_d     = acc_new | sext_mask;
          next_addr_d = cur_addr_q + 32'd1;
          error_d     = cur_byte[7];
          state_d     = DONE;
        end else begin
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      acc_q         <= '0;
      count_q       <= '0;
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_word_q  <= '0;
      value_q       <= '0;
      next_addr_q   <= '0;
      error_q       <= 1'b0;
`ifdef LEB128_SIGNED_EN
      signed_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      acc_q         <= acc_d;
      count_q       <= count_d;
      cache_valid_q <= cache_valid_d;
      cache_tag_q   <= cache_tag_d;
      cache_word_q  <= cache_word_d;
      value_q       <= value_d;
      next_addr_q   <= next_addr_d;
      error_q       <= error_d;
`ifdef LEB128_SIGNED_EN
      signed_q      <= signed_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign value     = value_q;
  assign next_addr = next_addr_q;
  assign error     = error_q;

  assign mem.mem_cmd_start = cmd_start;
  assign mem.mem_cmd_write = 1'b0;
  assign mem.mem_addr      = {cur_addr_q[31:2], 2'b00};
  assign mem.mem_wdata     = '0;
endmodule

// File: tb/tb_leb128_reader.sv
// Directed bench for leb128_reader against a 2 KiB word-read memory with one busy cycle per read.
module tb_leb128_reader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_addr = '0;
`ifdef LEB128_SIGNED_EN
  logic        signed_mode = 1'b0;
`endif
  logic        busy, done, error;
  logic [31:0] value, next_addr;

  int tests_run = 0;
  int tests_failed = 0;

  leb128_reader_if mif();

  always #5 clk = ~clk;

  leb128_reader #(.MAX_BYTES(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
`ifdef LEB128_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .busy       (busy),
    .done       (done),
    .value      (value),
    .next_addr  (next_addr),
    .error      (error),
    .mem        (mif.master)
  );

  // Memory model: accepts a command when ready, stays busy one cycle, then returns data with
  // ready and rdata_ready high together; rdata_ready is left high (stale) after completion.
  logic [7:0]  mem_bytes [0:2047];
  logic        m_busy = 1'b0;
  logic        m_cmd_ready = 1'b1;
  logic        m_rdata_ready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [31:0] m_addr = '0;
  int          read_cnt = 0;
  logic [31:0] read_log [0:255];
  int          done_cnt = 0;

  assign mif.mem_cmd_ready   = m_cmd_ready;
  assign mif.mem_rdata_ready = m_rdata_ready;
  assign mif.mem_rdata       = m_rdata;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    int b;
    b = int'({a[10:2], 2'b00});
    return {mem_bytes[b], mem_bytes[b+1], mem_bytes[b+2], mem_bytes[b+3]};
  endfunction

  always @(posedge clk) begin
    if (m_busy) begin
      m_rdata       <= word_at(m_addr);
      m_rdata_ready <= 1'b1;
      m_cmd_ready   <= 1'b1;
      m_busy        <= 1'b0;
    end else if (mif.mem_cmd_start && m_cmd_ready) begin
      m_busy      <= 1'b1;
      m_cmd_ready <= 1'b0;
      m_addr      <= mif.mem_addr;
      read_log[read_cnt[7:0]] <= mif.mem_addr;
      read_cnt    <= read_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic put(input int a, input logic [7:0] b);
    mem_bytes[a] = b;
  endtask

  // Runs one decode and checks result, done pulse width and returns latency/read info.
  task automatic run_decode(input string tag, input logic [31:0] addr, input logic sm,
                            input logic [31:0] exp_value, input logic [31:0] exp_next,
                            input logic exp_err, output int cycles, output int rbase,
                            output int nreads);
    int base_done;
    logic seen;
    @(negedge clk);
    rbase     = read_cnt;
    base_done = done_cnt;
`ifdef LEB128_SIGNED_EN
    signed_mode = sm;
`else
    if (sm) $display("[TB] %s: signed_mode requested on unsigned build", tag);
`endif
    start      = 1'b1;
    start_addr = addr;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 100) begin
      @(negedge clk);
      start = 1'b0;
      cycles++;
      if (done) seen = 1'b1;
    end
    check_eq({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check_eq({tag, "_value"}, value, exp_value);
    check_eq({tag, "_next_addr"}, next_addr, exp_next);
    check_eq({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
    @(negedge clk);
    check_eq({tag, "_done_cleared"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_done_pulses"}, 32'(done_cnt - base_done), 32'd1);
    check_eq({tag, "_value_held"}, value, exp_value);
    nreads = read_cnt - rbase;
    $display("[TB] %s: start=0x%08h value=0x%08h next=0x%08h err=%0b cycles=%0d reads=%0d",
             tag, addr, value, next_addr, error, cycles, nreads);
  endtask

  initial begin
    int cyc, rb, nr, base_done;
    logic [31:0] exp_s;

    for (int i = 0; i < 2048; i++) mem_bytes[i] = 8'h00;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_value", value, 32'd0);
    check_eq("rst_next_addr", next_addr, 32'd0);
    check_eq("rst_error", {31'd0, error}, 32'd0);
    check_eq("rst_cmd_start", {31'd0, mif.mem_cmd_start}, 32'd0);
    check_eq("rst_mem_addr", mif.mem_addr, 32'd0);
    check_eq("rst_wdata", mif.mem_wdata, 32'd0);
    check_eq("rst_cmd_write", {31'd0, mif.mem_cmd_write}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte: 5 cycles start->done, one read.
    put(16, 8'h05);
    run_decode("single", 32'h10, 1'b0, 32'd5, 32'h11, 1'b0, cyc, rb, nr);
    check_eq("single_latency", 32'(cyc), 32'd5);
    check_eq("single_reads", 32'(nr), 32'd1);
    check_eq("single_read_addr", read_log[rb[7:0]], 32'h10);

    // Three bytes within one word: one read.
    put(0, 8'hE5); put(1, 8'h8E); put(2, 8'h26);
    run_decode("three", 32'h0, 1'b0, 32'd624485, 32'h3, 1'b0, cyc, rb, nr);
    check_eq("three_reads", 32'(nr), 32'd1);
    check_eq("three_read_addr", read_log[rb[7:0]], 32'h0);

    // Crossing a word boundary: two reads.
    put(2, 8'h80); put(3, 8'h80); put(4, 8'h01);
    run_decode("cross", 32'h2, 1'b0, 32'h4000, 32'h5, 1'b0, cyc, rb, nr);
    check_eq("cross_reads", 32'(nr), 32'd2);
    check_eq("cross_read0", read_log[rb[7:0]], 32'h0);
    check_eq("cross_read1", read_log[8'(rb + 1)], 32'h4);

    // Continuation bit still set on the fifth byte.
    for (int i = 0; i < 5; i++) put(32 + i, 8'hFF);
    run_decode("overrun", 32'h20, 1'b0, 32'hFFFF_FFFF, 32'h25, 1'b1, cyc, rb, nr);

    // Address wrap: byte at 0xFFFFFFFF then at 0x00000000.
    put(2047, 8'h81); put(0, 8'h01);
    run_decode("wrap", 32'hFFFF_FFFF, 1'b0, 32'h81, 32'h1, 1'b0, cyc, rb, nr);
    check_eq("wrap_reads", 32'(nr), 32'd2);
    check_eq("wrap_read0", read_log[rb[7:0]], 32'hFFFF_FFFC);
    check_eq("wrap_read1", read_log[8'(rb + 1)], 32'h0);

    // Sign handling.
    put(64, 8'h7F);
    run_decode("u7f", 32'h40, 1'b0, 32'h7F, 32'h41, 1'b0, cyc, rb, nr);
`ifdef LEB128_SIGNED_EN
    exp_s = 32'hFFFF_FFFF;
`else
    exp_s = 32'h7F;
`endif
    run_decode("s7f", 32'h40, 1'b1, exp_s, 32'h41, 1'b0, cyc, rb, nr);
    put(80, 8'hC0); put(81, 8'hBB); put(82, 8'h78);
`ifdef LEB128_SIGNED_EN
    exp_s = 32'hFFFE_1DC0;
`else
    exp_s = 32'h001E_1DC0;
`endif
    run_decode("sneg", 32'h50, 1'b1, exp_s, 32'h53, 1'b0, cyc, rb, nr);
    run_decode("uneg", 32'h50, 1'b0, 32'h001E_1DC0, 32'h53, 1'b0, cyc, rb, nr);

    // Reset while waiting on memory.
    @(negedge clk);
    base_done  = done_cnt;
`ifdef LEB128_SIGNED_EN
    signed_mode = 1'b0;
`endif
    start      = 1'b1;
    start_addr = 32'h10;
    @(negedge clk);
    start = 1'b0;
    check_eq("rstmid_issue", {31'd0, mif.mem_cmd_start}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_busy", {31'd0, busy}, 32'd0);
    check_eq("rstmid_value", value, 32'd0);
    check_eq("rstmid_next_addr", next_addr, 32'd0);
    check_eq("rstmid_mem_addr", mif.mem_addr, 32'd0);
    check_eq("rstmid_cmd_start", {31'd0, mif.mem_cmd_start}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rstmid_no_done", 32'(done_cnt - base_done), 32'd0);
    check_eq("rstmid_idle", {31'd0, busy}, 32'd0);
    $display("[TB] rstmid: reset during read, done pulses=%0d", done_cnt - base_done);
    run_decode("after_rst", 32'h10, 1'b0, 32'd5, 32'h11, 1'b0, cyc, rb, nr);
    check_eq("after_rst_latency", 32'(cyc), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
